pipelined_csel_adder: RTL and testbench

//   Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface.

---
 rtl/csel_pkg.sv | 24 ++
 rtl/pipelined_csel_adder_block.sv | 33 +++
 rtl/pipelined_csel_adder.sv | 152 +++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: geometry functions and
// the per-stage control record carried alongside the datapath registers.
package csel_pkg;

  // Number of BLOCK-bit carry-select blocks across a w-bit operand.
  function automatic int nblk(input int w, input int b);
    return (b > 0) ? (w / b) : 0;
  endfunction

  // Blocks resolved by each pipeline stage.
  function automatic int bps(input int w, input int b, input int s);
    return (b > 0 && s > 0) ? ((w / b) / s) : 1;
  endfunction

  // Control state registered by every stage. c_msb is the carry into the
  // top bit of the stage's highest block; only the last stage's copy feeds
  // the signed-overflow output.
  typedef struct packed {
    logic valid;
    logic carry;
    logic c_msb;
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_csel_adder_block.sv
// One BLOCK-bit carry-select block: two precomputed sums (carry-in 0 and 1)
// followed by a mux on the real carry-in.
module csel_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK:0] r0;
  logic [BLOCK:0] r1;
  logic [BLOCK-1:0] sel_sum;

  // Speculative sums for both possible carry-ins.
  always_comb begin
    r0 = {1'b0, a} + {1'b0, b};
    r1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
  end

  // Select on the incoming carry; the carry into the MSB falls out of the
  // MSB sum bit and the two MSB operand bits.
  always_comb begin
    sel_sum = cin ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
    sum     = sel_sum;
    cout    = cin ? r1[BLOCK] : r0[BLOCK];
    c_msb   = sel_sum[BLOCK-1] ^ a[BLOCK-1] ^ b[BLOCK-1];
  end

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Stage s resolves its group of blocks combinationally from the previous
// stage's registers (stage 0 from the input ports) and registers the result,
// so a beat accepted at edge N is on the outputs after edge N+STAGES-1.
//
// Handshake: a beat transfers on a rising edge when valid and ready are both
// high. stall = out_valid & ~out_ready; in_ready = ~stall (combinational from
// out_ready). On stall every stage register holds; otherwise every stage,
// bubbles included, advances by one.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = nblk(WIDTH, BLOCK);
  localparam int BPS  = bps(WIDTH, BLOCK, STAGES);
  localparam int SB   = BPS * BLOCK;  // operand bits resolved per stage

  if (STAGES < 1) begin : g_err_stages
    $error("pipelined_csel_adder: STAGES must be at least 1");
  end
  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_err_block
    $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
  end
  if (STAGES >= 1 && (NBLK % STAGES) != 0) begin : g_err_nblk
    $error("pipelined_csel_adder: WIDTH/BLOCK must be a multiple of STAGES");
  end

  logic stall;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LO  = s * SB;        // first operand bit resolved here
    localparam int HI  = LO + SB;       // sum bits known after this stage
    localparam int REM = WIDTH - HI;    // operand bits still pending after

    // Operand bits not yet resolved on entry: [SB-1:0] are this stage's.
    logic [WIDTH-LO-1:0] opa;
    logic [WIDTH-LO-1:0] opb;
    logic                c_in;
    logic                v_in;

    logic [BPS:0]        cch;
    logic [SB-1:0]       blk_sum;
    logic [BPS-1:0]      blk_msb;

    stage_ctl_t          ctl_d, ctl_q;
    logic [HI-1:0]       sum_d, sum_q;

    if (s == 0) begin : g_src
      // b inversion and the forced carry-in for subtraction happen here,
      // before any block sees the operands.
      assign opa  = a;
      assign opb  = sub ? ~b : b;
      assign c_in = sub | cin;
      assign v_in = in_valid;

      // First stage starts the resolved-sum field.
      always_comb sum_d = blk_sum;
    end else begin : g_src
      assign opa  = g_stage[s-1].g_pend.a_q;
      assign opb  = g_stage[s-1].g_pend.b_q;
      assign c_in = g_stage[s-1].ctl_q.carry;
      assign v_in = g_stage[s-1].ctl_q.valid;

      // Append this stage's blocks above the already-resolved sum bits.
      always_comb sum_d = {blk_sum, g_stage[s-1].sum_q};
    end

    assign cch[0] = c_in;

    for (genvar j = 0; j < BPS; j++) begin : g_blk
      csel_block #(
        .BLOCK(BLOCK)
      ) u_blk (
        .a     (opa[j*BLOCK +: BLOCK]),
        .b     (opb[j*BLOCK +: BLOCK]),
        .cin   (cch[j]),
        .sum   (blk_sum[j*BLOCK +: BLOCK]),
        .cout  (cch[j+1]),
        .c_msb (blk_msb[j])
      );
    end

    // Control for the next register: valid follows the beat, carry and
    // MSB carry come from this stage's top block.
    always_comb begin
      ctl_d       = '0;
      ctl_d.valid = v_in;
      ctl_d.carry = cch[BPS];
      ctl_d.c_msb = blk_msb[BPS-1];
    end

    // Stage register: cleared by reset, frozen while the output stalls.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (!stall) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    if (REM > 0) begin : g_pend
      logic [REM-1:0] a_d, a_q;
      logic [REM-1:0] b_d, b_q;

      // Forward the operand bits later stages still have to resolve.
      always_comb begin
        a_d = opa[WIDTH-LO-1:SB];
        b_d = opb[WIDTH-LO-1:SB];
      end

      // Pending-operand register, same hold rule as the rest of the stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].ctl_q.valid;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].ctl_q.carry;
  assign ovf       = g_stage[STAGES-1].ctl_q.carry ^ g_stage[STAGES-1].ctl_q.c_msb;

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: reset state, directed vector table with
// latency measurement, randomized backpressured stream against an
// arithmetic reference model, and reset with beats in flight.
module tb_pipelined_csel_adder;

  localparam int W   = 64;
  localparam int BLK = 8;
  localparam int ST  = 4;
  localparam int NRAND = 200;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  pipelined_csel_adder #(
    .WIDTH (W),
    .BLOCK (BLK),
    .STAGES(ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [W+1:0] act, input logic [W+1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: unsigned and signed results computed with plain arithmetic.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic s);
    logic [W:0]          u;
    logic signed [W+1:0] sv;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    logic                cy;
    logic                ov;
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = $signed({3'b111, {(W-1){1'b0}}});
    if (s) begin
      u  = {1'b0, x} - {1'b0, y};
      cy = (x >= y);
      sv = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y});
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      cy = u[W];
      sv = $signed({{2{x[W-1]}}, x}) + $signed({{2{y[W-1]}}, y}) + $signed({{(W+1){1'b0}}, ci});
    end
    ov = (sv > smax) || (sv < smin);
    return {cy, ov, u[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] r;
    int           k;
    r = '0;
    for (int i = 0; i < W; i += 32) r = (r << 32) | W'($urandom);
    k = $urandom_range(0, 15);
    if (k == 0) r = '1;
    else if (k == 1) r = '0;
    else if (k == 2) r = {1'b0, {(W-1){1'b1}}};
    else if (k == 3) r = {1'b1, {(W-1){1'b0}}};
    return r;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
  endtask

  // Single beat through an empty pipe; measures latency and checks outputs.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    drive_idle();
    out_ready = 1'b1;
    repeat (ST + 1) @(posedge clk);
    #1;
    a = v.a;
    b = v.b;
    cin = v.cin;
    sub = v.sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < ST + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d latency", idx), (W+2)'(lat), (W+2)'(ST));
    check($sformatf("vec%0d sum", idx), (W+2)'(sum), (W+2)'(v.sum));
    check($sformatf("vec%0d cout", idx), (W+2)'(cout), (W+2)'(v.cout));
    check($sformatf("vec%0d ovf", idx), (W+2)'(ovf), (W+2)'(v.ovf));
  endtask

  task automatic run_random();
    int           sent;
    int           got;
    int           cyc;
    logic         acc;
    logic         was_stall;
    logic [W+1:0] held;
    logic [W+1:0] e;
    sent = 0;
    got = 0;
    cyc = 0;
    acc = 1'b0;
    was_stall = 1'b0;
    held = '0;
    drive_idle();
    while ((sent < NRAND || got < sent) && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (was_stall) begin
        check("stall hold valid", (W+2)'(out_valid), (W+2)'(1));
        check("stall hold data", {cout, ovf, sum}, held);
      end
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < NRAND) begin
        a = rand_operand();
        b = rand_operand();
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_model(a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected result beat", (W+2)'(1), (W+2)'(0));
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rand beat %0d", got), {cout, ovf, sum}, e);
        end
        got++;
      end
      was_stall = out_valid && !out_ready;
      held = {cout, ovf, sum};
    end
    in_valid = 1'b0;
    check("random beats received", (W+2)'(got), (W+2)'(NRAND));
    check("random queue drained", (W+2)'(exp_q.size()), (W+2)'(0));
  endtask

  task automatic run_reset_inflight();
    int n;
    int seen;
    drive_idle();
    out_ready = 1'b1;
    repeat (ST + 1) @(posedge clk);
    #1;
    out_ready = 1'b0;
    a = rand_operand();
    b = rand_operand();
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < ST + 4) begin
      @(posedge clk);
      #1;
      n++;
      a = rand_operand();
    end
    check("reset test filled", (W+2)'(out_valid), (W+2)'(1));
    #2;
    rst = 1'b1;
    #1;
    check("reset mid-cycle out_valid", (W+2)'(out_valid), (W+2)'(0));
    check("reset mid-cycle sum", (W+2)'(sum), (W+2)'(0));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (3 * ST) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("no result after reset", (W+2)'(seen), (W+2)'(0));
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive_idle();

    vecs[0] = '{a: '1, b: W'(1), cin: 1'b0, sub: 1'b0,
                sum: '0, cout: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: {1'b0, {(W-1){1'b1}}}, b: W'(1), cin: 1'b0, sub: 1'b0,
                sum: {1'b1, {(W-1){1'b0}}}, cout: 1'b0, ovf: 1'b1};
    vecs[2] = '{a: W'(5), b: W'(7), cin: 1'b0, sub: 1'b1,
                sum: {{(W-1){1'b1}}, 1'b0}, cout: 1'b0, ovf: 1'b0};
    vecs[3] = '{a: W'(7), b: W'(5), cin: 1'b1, sub: 1'b1,
                sum: W'(2), cout: 1'b1, ovf: 1'b0};
    vecs[4] = '{a: {1'b1, {(W-1){1'b0}}}, b: W'(1), cin: 1'b0, sub: 1'b1,
                sum: {1'b0, {(W-1){1'b1}}}, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: '0, b: '0, cin: 1'b1, sub: 1'b0,
                sum: W'(1), cout: 1'b0, ovf: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", (W+2)'(out_valid), (W+2)'(0));
    check("reset sum", (W+2)'(sum), (W+2)'(0));
    check("reset cout", (W+2)'(cout), (W+2)'(0));
    check("reset ovf", (W+2)'(ovf), (W+2)'(0));
    check("reset in_ready", (W+2)'(in_ready), (W+2)'(1));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    run_random();
    run_reset_inflight();
    run_vec(vecs[1], 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
